ecc_error_corrector: RTL

Parametrised, pipelined successor to the single-word error-fix stage of the ECC decoder. It takes a received codeword plus the syndrome and error-count classification from the upstream checker, corrects single-bit errors in any of three codeword sizes, and flags uncorrectable words. It sits between the syndrome checker and the APB/AMBA read-data path, with valid/ready flow control and optional error statistics.

---
 rtl/ecc_error_corrector.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/ecc_error_corrector.sv
// ecc_error_corrector: two-stage valid/ready corrector for single-bit errors in three codeword widths.
// Error statistics counters are built only when ECC_ERR_STATS_EN is defined.
module ecc_error_corrector #(
  parameter int  DATA_WIDTH = 32,
  parameter int  CNT_WIDTH  = 16,
  localparam int SYN_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_codeword_i,
  input  logic [SYN_WIDTH-1:0]  in_syndrome_i,
  input  logic [1:0]            in_nof_i,
  input  logic [1:0]            in_mode_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_codeword_o,
  output logic [1:0]            out_status_o,
  input  logic                  cnt_clr_i,
  output logic [CNT_WIDTH-1:0]  cnt_corrected_o,
  output logic [CNT_WIDTH-1:0]  cnt_uncorrectable_o
);

  typedef enum logic [1:0] {
    ST_CLEAN  = 2'd0,
    ST_CORR   = 2'd1,
    ST_UNCORR = 2'd2
  } status_e;

  localparam logic [SYN_WIDTH:0]    W_FULL    = (SYN_WIDTH+1)'(DATA_WIDTH);
  localparam logic [SYN_WIDTH:0]    W_ONE     = (SYN_WIDTH+1)'(1);
  localparam logic [SYN_WIDTH-1:0]  SYN_ZERO  = {SYN_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ZERO_W    = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] LSB_ONE   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] KEEP_FULL = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] KEEP_HALF = {{(DATA_WIDTH/2){1'b0}}, {(DATA_WIDTH/2){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] KEEP_QTR  = {{(DATA_WIDTH-DATA_WIDTH/4){1'b0}}, {(DATA_WIDTH/4){1'b1}}};

  // Syndrome 0 points at the overall parity bit, the top bit of the active width.
  function automatic logic [DATA_WIDTH-1:0] flip_mask(input logic [SYN_WIDTH:0]   width,
                                                      input logic [SYN_WIDTH-1:0] syn);
    logic [SYN_WIDTH:0] idx;
    if (syn == SYN_ZERO) begin
      idx = width - W_ONE;
    end else begin
      idx = {1'b0, syn} - W_ONE;
    end
    return LSB_ONE << idx;
  endfunction

  logic [SYN_WIDTH:0]    dec_width_s;
  logic [DATA_WIDTH-1:0] dec_keep_s;
  logic                  dec_mode_ok_s;
  logic [DATA_WIDTH-1:0] dec_code_s;
  logic [DATA_WIDTH-1:0] dec_mask_s;
  status_e               dec_status_s;

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_code_q, s1_code_d;
  logic [DATA_WIDTH-1:0] s1_mask_q, s1_mask_d;
  status_e               s1_status_q, s1_status_d;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_code_q, out_code_d;
  status_e               out_status_q, out_status_d;

  logic                  s1_adv_s;
  logic                  s2_adv_s;

  // Decode: active width, masking of unused upper bits and the one-hot flip mask.
  always_comb begin
    dec_width_s   = W_FULL;
    dec_keep_s    = KEEP_FULL;
    dec_mode_ok_s = 1'b1;
    case (in_mode_i)
      2'd0: begin
        dec_width_s = W_FULL >> 2'd2;
        dec_keep_s  = KEEP_QTR;
      end
      2'd1: begin
        dec_width_s = W_FULL >> 2'd1;
        dec_keep_s  = KEEP_HALF;
      end
      2'd2: begin
        dec_width_s = W_FULL;
        dec_keep_s  = KEEP_FULL;
      end
      default: begin
        dec_width_s   = W_FULL;
        dec_keep_s    = KEEP_FULL;
        dec_mode_ok_s = 1'b0;
      end
    endcase

    dec_code_s   = in_codeword_i & dec_keep_s;
    dec_mask_s   = ZERO_W;
    dec_status_s = ST_UNCORR;
    if (!dec_mode_ok_s || in_nof_i[1]) begin
      dec_mask_s   = ZERO_W;
      dec_status_s = ST_UNCORR;
    end else if (in_nof_i == 2'd0) begin
      dec_mask_s   = ZERO_W;
      dec_status_s = ST_CLEAN;
    end else if ({1'b0, in_syndrome_i} >= dec_width_s) begin
      dec_mask_s   = ZERO_W;
      dec_status_s = ST_UNCORR;
    end else begin
      dec_mask_s   = flip_mask(dec_width_s, in_syndrome_i);
      dec_status_s = ST_CORR;
    end
  end

  assign s2_adv_s   = !out_valid_q || out_ready_i;
  assign s1_adv_s   = !s1_valid_q || s2_adv_s;
  assign in_ready_o = s1_adv_s;

  // Pipeline next state: each stage loads only when its downstream slot frees up.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_code_d    = s1_code_q;
    s1_mask_d    = s1_mask_q;
    s1_status_d  = s1_status_q;
    out_valid_d  = out_valid_q;
    out_code_d   = out_code_q;
    out_status_d = out_status_q;

    if (s1_adv_s) begin
      s1_valid_d = in_valid_i;
      if (in_valid_i) begin
        s1_code_d   = dec_code_s;
        s1_mask_d   = dec_mask_s;
        s1_status_d = dec_status_s;
      end else begin
        s1_code_d   = s1_code_q;
        s1_mask_d   = s1_mask_q;
        s1_status_d = s1_status_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s2_adv_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_code_d   = s1_code_q ^ s1_mask_q;
        out_status_d = s1_status_q;
      end else begin
        out_code_d   = out_code_q;
        out_status_d = out_status_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline registers; reset drops any in-flight words.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= ZERO_W;
      s1_mask_q    <= ZERO_W;
      s1_status_q  <= ST_CLEAN;
      out_valid_q  <= 1'b0;
      out_code_q   <= ZERO_W;
      out_status_q <= ST_CLEAN;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_code_q    <= s1_code_d;
      s1_mask_q    <= s1_mask_d;
      s1_status_q  <= s1_status_d;
      out_valid_q  <= out_valid_d;
      out_code_q   <= out_code_d;
      out_status_q <= out_status_d;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign out_codeword_o = out_code_q;
  assign out_status_o   = out_status_q;

`ifdef ECC_ERR_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_corr_q, cnt_corr_d;
  logic [CNT_WIDTH-1:0] cnt_unc_q, cnt_unc_d;
  logic                 out_xfer_s;

  assign out_xfer_s = out_valid_q && out_ready_i;

  // Saturating statistics; clear takes priority over a same-cycle delivery.
  always_comb begin
    cnt_corr_d = cnt_corr_q;
    cnt_unc_d  = cnt_unc_q;
    if (cnt_clr_i) begin
      cnt_corr_d = {CNT_WIDTH{1'b0}};
      cnt_unc_d  = {CNT_WIDTH{1'b0}};
    end else if (out_xfer_s && (out_status_q == ST_CORR) && !(&cnt_corr_q)) begin
      cnt_corr_d = cnt_corr_q + CNT_WIDTH'(1);
    end else if (out_xfer_s && (out_status_q == ST_UNCORR) && !(&cnt_unc_q)) begin
      cnt_unc_d = cnt_unc_q + CNT_WIDTH'(1);
    end else begin
      cnt_corr_d = cnt_corr_q;
      cnt_unc_d  = cnt_unc_q;
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_corr_q <= {CNT_WIDTH{1'b0}};
      cnt_unc_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      cnt_corr_q <= cnt_corr_d;
      cnt_unc_q  <= cnt_unc_d;
    end
  end

  assign cnt_corrected_o     = cnt_corr_q;
  assign cnt_uncorrectable_o = cnt_unc_q;
`else
  logic unused_cnt_clr_s;
  assign unused_cnt_clr_s    = cnt_clr_i;
  assign cnt_corrected_o     = {CNT_WIDTH{1'b0}};
  assign cnt_uncorrectable_o = {CNT_WIDTH{1'b0}};
`endif

endmodule
